// File: rtl/car_sample_scheduler.sv
// car_sample_scheduler: sample-rate tick generator, input sample FIFO and
//   issue/collect sequencer in front of the CAR filter bank.
// Ports: clk/rst_i (sync, active-high), enable_i; tick_o to the sample source;
//   src_valid_i/src_data_i/src_ready_o sample input; car_valid_o/car_x_o/car_ready_i
//   CAR input handshake; car_valid_i/car_ready_o CAR output handshake gated by
//   out_ready_i; status: frame_done_o, frame_idx_o, overrun_cnt_o, busy_o, timeout_o.
// Optional watchdog: define CAR_SCHED_TIMEOUT_EN to abort a BUSY phase after
//   TIMEOUT_CYCLES cycles; when undefined timeout_o is tied 0.
module car_sample_scheduler #(
  parameter int DATA_W         = 36,
  parameter int FIFO_DEPTH     = 4,
  parameter int TICK_DIV       = 4167,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              enable_i,
  output logic              tick_o,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] src_data_i,
  output logic              src_ready_o,
  output logic              car_valid_o,
  output logic [DATA_W-1:0] car_x_o,
  input  logic              car_ready_i,
  input  logic              car_valid_i,
  output logic              car_ready_o,
  input  logic              out_ready_i,
  output logic              frame_done_o,
  output logic [CNT_W-1:0]  frame_idx_o,
  output logic [CNT_W-1:0]  overrun_cnt_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TICK_DIV < 2 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("car_sample_scheduler: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
  state_t state, state_n;

  // ---------------- sample-rate tick ----------------
  logic [TICK_W-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (rst_i || !enable_i) tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick_o = enable_i && (tick_cnt == TICK_LAST);

  // ---------------- input FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              full, empty, push, pop;

  assign full        = (occ == OCC_W'(FIFO_DEPTH));
  assign empty       = (occ == '0);
  assign src_ready_o = !full;
  // full is taken from registered occupancy, so a same-cycle pop never frees a slot
  assign push        = src_valid_i && !full;
  assign pop         = (state == ISSUE) && car_ready_i;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= src_data_i;
  end

  // power-of-2 depth: pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // ---------------- watchdog ----------------
  logic frame_hs, wd_fire;
  assign frame_hs = (state == BUSY) && car_valid_i && out_ready_i;

`ifdef CAR_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // a handshake in the expiry cycle takes priority over the abort
  assign wd_fire = (state == BUSY) && (wd_cnt == WD_LAST) && !frame_hs;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (pop) wd_cnt <= '0;
      else if (state == BUSY) wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable_i && !empty) state_n = ISSUE;
      ISSUE:   if (car_ready_i) state_n = BUSY;
      BUSY:    if (frame_hs || wd_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign car_valid_o = (state == ISSUE);
  assign car_x_o     = (state == ISSUE) ? mem[rd_ptr] : '0;
  assign car_ready_o = (state == BUSY) && out_ready_i;
  assign busy_o      = (state != IDLE);

  // ---------------- status counters ----------------
  always_ff @(posedge clk) begin
    if (rst_i) begin
      frame_done_o  <= 1'b0;
      frame_idx_o   <= '0;
      overrun_cnt_o <= '0;
    end else begin
      frame_done_o <= frame_hs;
      if (frame_hs) frame_idx_o <= frame_idx_o + 1'b1;
      if (src_valid_i && full && (overrun_cnt_o != '1))
        overrun_cnt_o <= overrun_cnt_o + 1'b1;
    end
  end

endmodule
